// File: rtl/race_referee_pkg.sv
// race_pkg
//   Shared definitions for race control. The physics engines import the same
//   package so that motion gating compares against ST_RACE instead of a bare 4.
//   Contents:
//     race_state_e : game state encoding driven on the referee's o_state
//     sector_e     : track quadrant codes, numbered in lap order
//     sector_of()  : maps a 10-bit position onto a quadrant

package race_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT3   = 3'd1,
        ST_CNT2   = 3'd2,
        ST_CNT1   = 3'd3,
        ST_RACE   = 3'd4,
        ST_FINISH = 3'd5
    } race_state_e;

    // Quadrants in the order a car must cross them: NW, NE, SE, SW.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } sector_e;

    function automatic sector_e sector_of(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] cx,
        input logic [9:0] cy
    );
        logic west;
        logic north;
        sector_e s;
        west  = (x < cx);
        north = (y < cy);
        case ({west, north})
            2'b11:   s = S0;
            2'b01:   s = S1;
            2'b00:   s = S2;
            default: s = S3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/race_referee_lap_tracker.sv
// lap_tracker
//   Follows one car around the four quadrants and counts completed laps.
//   A lap is only credited when the quadrants are crossed in order
//   S0 -> S1 -> S2 -> S3; anything else (reversing, skipping, parking) simply
//   leaves the tracker waiting for the quadrant it expects next.
// Ports
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear back to "expect S0, nothing visited"
//   i_sample       : take the current position into account this cycle
//   i_x, i_y       : car position
//   o_lap          : completed laps, saturating at 3
//   o_lap_done     : high in the cycle whose sample lifts o_lap to NUM_LAPS

module lap_tracker
    import race_pkg::*;
#(
    parameter int         NUM_LAPS = 3,
    parameter logic [9:0] CX       = 10'd160,
    parameter logic [9:0] CY       = 10'd120
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_sample,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output logic [1:0] o_lap,
    output logic       o_lap_done
);

    sector_e    r_expect;
    logic [1:0] r_visited;
    logic [1:0] r_lap;

    sector_e    w_sector;
    logic       w_hit;
    logic       w_lap_inc;
    logic [1:0] w_lap_next;

    assign w_sector   = sector_of(i_x, i_y, CX, CY);
    assign w_hit      = i_sample && (w_sector == r_expect);
    assign w_lap_inc  = w_hit && (w_sector == S3) && (r_visited == 2'd3);
    assign w_lap_next = (r_lap == 2'd3) ? 2'd3 : r_lap + 2'd1;

    // Flagged on the completing sample itself so the referee can latch the
    // winner and enter FINISH on the same edge that updates the lap count.
    assign o_lap_done = w_lap_inc && (r_lap == 2'(NUM_LAPS - 1));
    assign o_lap      = r_lap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_expect  <= S0;
            r_visited <= 2'd0;
            r_lap     <= 2'd0;
        end else if (i_clr) begin
            r_expect  <= S0;
            r_visited <= 2'd0;
            r_lap     <= 2'd0;
        end else if (w_hit) begin
            r_expect <= sector_e'(2'(r_expect + 2'd1));
            if (w_lap_inc) begin
                r_visited <= 2'd0;
                r_lap     <= w_lap_next;
            end else begin
                r_visited <= r_visited + 2'd1;
            end
        end
    end

endmodule

// File: rtl/race_referee.sv
// race_referee
//   Race control around the two physics engines: runs the start countdown,
//   publishes the shared game state, tracks both cars' laps, times the race
//   in game ticks and latches the winner until the next start press.
// Ports
//   i_clk, i_rst_n        : system clock, async active-low reset
//   i_start_btn           : synchronised start/restart level (rising edge used)
//   i_p1_x/y, i_p2_x/y    : car positions from the engines
//   o_state               : game state (race_state_e encoding)
//   o_race_rst            : one-cycle pulse when a new race is armed
//   o_p1_lap, o_p2_lap    : completed laps per car
//   o_winner              : 0 none, 1 car 1, 2 car 2, 3 tie
//   o_race_time           : game ticks spent racing, saturating
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a start press
// ST_CNT3   | countdown "3", CNT_TICKS ticks long
// ST_CNT2   | countdown "2"
// ST_CNT1   | countdown "1"
// ST_RACE   | cars move; trackers sample every tick; timer runs
// ST_FINISH | results frozen until the next start press
// 6, 7      | illegal, recover to ST_IDLE on the next clock

module race_referee
    import race_pkg::*;
#(
    parameter int         CLK_FREQ  = 100_000_000,
    parameter int         NUM_LAPS  = 3,
    parameter int         CNT_TICKS = 60,
    parameter logic [9:0] CX        = 10'd160,
    parameter logic [9:0] CY        = 10'd120
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_btn,
    input  logic [9:0]  i_p1_x,
    input  logic [9:0]  i_p1_y,
    input  logic [9:0]  i_p2_x,
    input  logic [9:0]  i_p2_y,
    output logic [2:0]  o_state,
    output logic        o_race_rst,
    output logic [1:0]  o_p1_lap,
    output logic [1:0]  o_p2_lap,
    output logic [1:0]  o_winner,
    output logic [15:0] o_race_time
);

    // The tick period is TICK_MAX+1 clocks; the counter runs down and the
    // tick is its terminal count, so the first cycle out of reset is a tick.
    localparam int TICK_MAX = CLK_FREQ / 60;
    localparam int TW       = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int SW       = (CNT_TICKS > 1) ? $clog2(CNT_TICKS) : 1;
    localparam logic [SW-1:0] STEP_LOAD = SW'(CNT_TICKS - 1);

    logic [TW-1:0] r_tick_cnt;
    logic          r_start_q;
    race_state_e   r_state;
    logic [SW-1:0] r_step;
    logic          r_race_rst;
    logic [1:0]    r_winner;
    logic [15:0]   r_race_time;

    logic          w_tick;
    logic          w_start_edge;
    logic          w_in_cnt;
    logic          w_sample;
    logic          w_clr;
    logic          w_p1_done;
    logic          w_p2_done;
    race_state_e   w_state_next;

    assign w_tick       = (r_tick_cnt == '0);
    assign w_start_edge = i_start_btn & ~r_start_q;
    assign w_in_cnt     = (r_state == ST_CNT3) || (r_state == ST_CNT2) ||
                          (r_state == ST_CNT1);
    assign w_sample     = w_tick && (r_state == ST_RACE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= TW'(TICK_MAX);
        end else begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= i_start_btn;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = ST_CNT3;
                    w_clr        = 1'b1;
                end
            end
            ST_CNT3: begin
                if (w_tick && (r_step == '0)) w_state_next = ST_CNT2;
            end
            ST_CNT2: begin
                if (w_tick && (r_step == '0)) w_state_next = ST_CNT1;
            end
            ST_CNT1: begin
                if (w_tick && (r_step == '0)) w_state_next = ST_RACE;
            end
            ST_RACE: begin
                if (w_p1_done || w_p2_done) w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                if (w_start_edge) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Countdown step timer: reloaded when a race is armed and again each
    // time a countdown state expires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step <= '0;
        end else if (w_clr) begin
            r_step <= STEP_LOAD;
        end else if (w_in_cnt && w_tick) begin
            if (r_step == '0) begin
                r_step <= STEP_LOAD;
            end else begin
                r_step <= r_step - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_race_rst <= 1'b0;
        end else begin
            r_race_rst <= w_clr;
        end
    end

    // Each done flag lands in its own bit, so a same-tick finish reads 3.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_winner <= 2'd0;
        end else if (w_clr) begin
            r_winner <= 2'd0;
        end else if ((r_state == ST_RACE) && (w_p1_done || w_p2_done)) begin
            r_winner <= {w_p2_done, w_p1_done};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_race_time <= 16'd0;
        end else if (w_clr) begin
            r_race_time <= 16'd0;
        end else if (w_sample && (r_race_time != 16'hFFFF)) begin
            r_race_time <= r_race_time + 16'd1;
        end
    end

    lap_tracker #(
        .NUM_LAPS (NUM_LAPS),
        .CX       (CX),
        .CY       (CY)
    ) u_trk_p1 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_sample   (w_sample),
        .i_x        (i_p1_x),
        .i_y        (i_p1_y),
        .o_lap      (o_p1_lap),
        .o_lap_done (w_p1_done)
    );

    lap_tracker #(
        .NUM_LAPS (NUM_LAPS),
        .CX       (CX),
        .CY       (CY)
    ) u_trk_p2 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_sample   (w_sample),
        .i_x        (i_p2_x),
        .i_y        (i_p2_y),
        .o_lap      (o_p2_lap),
        .o_lap_done (w_p2_done)
    );

    assign o_state     = r_state;
    assign o_race_rst  = r_race_rst;
    assign o_winner    = r_winner;
    assign o_race_time = r_race_time;

endmodule

// File: tb/tb_race_referee.sv
// Bench for race_referee. Two instances share all inputs: index 0 races to
// three laps, index 1 to a single lap. A behavioural model counts in-order
// quadrant hits per car (laps = hits/4) and follows the game rules edge by edge.

module tb_race_referee;

    localparam int CLKF = 600;
    localparam int CNTT = 2;
    localparam int TPER = CLKF / 60 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       btn;
    logic [9:0] p1x, p1y, p2x, p2y;

    logic [2:0]  st [2];
    logic        rr [2];
    logic [1:0]  l1 [2];
    logic [1:0]  l2 [2];
    logic [1:0]  win [2];
    logic [15:0] rt [2];

    race_referee #(.CLK_FREQ(CLKF), .NUM_LAPS(3), .CNT_TICKS(CNTT)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_btn(btn),
        .i_p1_x(p1x), .i_p1_y(p1y), .i_p2_x(p2x), .i_p2_y(p2y),
        .o_state(st[0]), .o_race_rst(rr[0]), .o_p1_lap(l1[0]), .o_p2_lap(l2[0]),
        .o_winner(win[0]), .o_race_time(rt[0])
    );

    race_referee #(.CLK_FREQ(CLKF), .NUM_LAPS(1), .CNT_TICKS(CNTT)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_btn(btn),
        .i_p1_x(p1x), .i_p1_y(p1y), .i_p2_x(p2x), .i_p2_y(p2y),
        .o_state(st[1]), .o_race_rst(rr[1]), .o_p1_lap(l1[1]), .o_p2_lap(l2[1]),
        .o_winner(win[1]), .o_race_time(rt[1])
    );

    int total = 0;
    int bad   = 0;

    int m_state [2];
    int m_cd    [2];
    int m_hits  [2][2];
    int m_time  [2];
    int m_win   [2];
    bit m_rr    [2];
    bit m_btn_q;
    int nl [2] = '{3, 1};
    int cyc;
    int ticks;

    function automatic int sec_of(input logic [9:0] x, input logic [9:0] y);
        if (x < 10'd160) return (y < 10'd120) ? 0 : 3;
        return (y < 10'd120) ? 1 : 2;
    endfunction

    function automatic int mlap(input int d, input int c);
        int l;
        l = m_hits[d][c] / 4;
        return (l > 3) ? 3 : l;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_cd[d] = 0; m_time[d] = 0; m_win[d] = 0; m_rr[d] = 0;
            m_hits[d][0] = 0; m_hits[d][1] = 0;
        end
        m_btn_q = 0;
    endtask

    task automatic model_edge(input int d, input bit tk, input bit se);
        int sec [2];
        int w;
        sec[0] = sec_of(p1x, p1y);
        sec[1] = sec_of(p2x, p2y);
        m_rr[d] = 0;
        case (m_state[d])
            0: if (se) begin
                m_state[d] = 1; m_cd[d] = 0; m_time[d] = 0; m_win[d] = 0; m_rr[d] = 1;
                m_hits[d][0] = 0; m_hits[d][1] = 0;
            end
            1, 2, 3: if (tk) begin
                m_cd[d]++;
                if (m_cd[d] == CNTT) begin
                    m_state[d]++;
                    m_cd[d] = 0;
                end
            end
            4: if (tk) begin
                if (m_time[d] < 65535) m_time[d]++;
                w = 0;
                for (int c = 0; c < 2; c++) begin
                    if (sec[c] == m_hits[d][c] % 4) m_hits[d][c]++;
                    if (mlap(d, c) >= nl[d]) w += (c == 0) ? 1 : 2;
                end
                if (w != 0) begin
                    m_state[d] = 5;
                    m_win[d] = w;
                end
            end
            default: if (se) m_state[d] = 0;
        endcase
    endtask

    task automatic chk(input string tag, input int d, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("state", d, 16'(st[d]), 16'(m_state[d]));
            chk("race_rst", d, 16'(rr[d]), 16'(m_rr[d]));
            chk("p1_lap", d, 16'(l1[d]), 16'(mlap(d, 0)));
            chk("p2_lap", d, 16'(l2[d]), 16'(mlap(d, 1)));
            chk("winner", d, 16'(win[d]), 16'(m_win[d]));
            chk("race_time", d, rt[d], 16'(m_time[d]));
        end
    endtask

    task automatic step();
        bit tk, se;
        @(posedge clk);
        tk = ((cyc % TPER) == 0);
        se = btn & ~m_btn_q;
        m_btn_q = btn;
        model_edge(0, tk, se);
        model_edge(1, tk, se);
        cyc++;
        if (tk) ticks++;
        #1;
        check_all();
    endtask

    task automatic wait_ticks(input int n);
        int target, g;
        target = ticks + n;
        g = 0;
        while (ticks < target && g < TPER * (n + 1)) begin
            step();
            g++;
        end
    endtask

    task automatic wait_model_state(input int s);
        int g;
        g = 0;
        while (m_state[0] != s && g < 20 * TPER) begin
            step();
            g++;
        end
    endtask

    task automatic set_pos(input int c, input int s);
        logic [9:0] x, y;
        bit edge_pt;
        edge_pt = ($urandom_range(0, 3) == 0);
        if (s == 0 || s == 3) x = edge_pt ? 10'd159 : 10'($urandom_range(0, 158));
        else                  x = edge_pt ? 10'd160 : 10'($urandom_range(161, 1023));
        if (s == 0 || s == 1) y = edge_pt ? 10'd119 : 10'($urandom_range(0, 118));
        else                  y = edge_pt ? 10'd120 : 10'($urandom_range(121, 1023));
        if (c == 0) begin p1x = x; p1y = y; end
        else        begin p2x = x; p2y = y; end
    endtask

    task automatic race_tick(input int s1, input int s2);
        set_pos(0, s1);
        set_pos(1, s2);
        wait_ticks(1);
    endtask

    task automatic start_race(input bit full);
        int t0, g;
        btn = 1'b1;
        step();
        t0 = ticks;
        chk("race_rst_on", 0, 16'(rr[0]), 16'd1);
        chk("state_cnt3", 0, 16'(st[0]), 16'd1);
        btn = 1'b0;
        step();
        chk("race_rst_off", 0, 16'(rr[0]), 16'd0);
        if (full) begin
            g = 0;
            while (ticks < t0 + 3 * CNTT && g < 10 * TPER) begin
                step();
                g++;
            end
            chk("race_after_6_ticks", 0, 16'(st[0]), 16'd4);
            chk("race_after_6_ticks", 1, 16'(st[1]), 16'd4);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, n, tf;
        rst_n = 1'b0;
        btn   = 1'b0;
        p1x = 10'd0; p1y = 10'd120; p2x = 10'd0; p2y = 10'd120;
        model_reset();
        cyc = 0;
        ticks = 0;
        #12;
        check_all();
        rst_n = 1'b1;
        repeat (3) step();

        // Countdown to RACE
        start_race(1'b1);

        // One clean lap for car 1
        race_tick(3, 3);
        for (int s = 0; s < 4; s++) race_tick(s, 3);
        chk("lap_after_clean_path", 0, 16'(l1[0]), 16'd1);
        chk("car2_no_lap", 0, 16'(l2[0]), 16'd0);
        chk("no_winner_yet", 0, 16'(win[0]), 16'd0);
        chk("single_lap_winner", 1, 16'(win[1]), 16'd1);

        // Skipped and backwards sectors
        race_tick(3, 3);
        race_tick(1, 3);
        race_tick(0, 3);
        race_tick(3, 3);
        chk("lap_after_bad_path", 0, 16'(l1[0]), 16'd1);

        // Random run, biased toward progress, until the 3-lap race ends
        n = 0;
        while (m_state[0] == 4 && n < 300) begin
            s0 = ($urandom_range(0, 1) == 1) ? m_hits[0][0] % 4 : int'($urandom_range(0, 3));
            s1 = ($urandom_range(0, 1) == 1) ? m_hits[0][1] % 4 : int'($urandom_range(0, 3));
            race_tick(s0, s1);
            n++;
        end
        chk("random_race_finished", 0, 16'(st[0]), 16'd5);

        // Back to IDLE, start again, press during CNT2
        btn = 1'b1; step();
        btn = 1'b0; step();
        chk("finish_to_idle", 0, 16'(st[0]), 16'd0);
        start_race(1'b0);
        wait_model_state(2);
        btn = 1'b1;
        step();
        step();
        chk("cnt2_ignores_start", 0, 16'(st[0]), 16'd2);
        wait_model_state(4);

        // Both cars complete a lap on the same tick
        p1x = 10'd0; p1y = 10'd120; p2x = 10'd0; p2y = 10'd120;
        race_tick(3, 3);
        for (int s = 0; s < 4; s++) race_tick(s, s);
        chk("tie_state", 1, 16'(st[1]), 16'd5);
        chk("tie_winner", 1, 16'(win[1]), 16'd3);
        tf = m_time[1];
        race_tick(3, 3);
        race_tick(3, 3);
        chk("race_time_frozen", 1, rt[1], 16'(tf));
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 4; s++) race_tick(s, s);
        chk("tie_winner_3laps", 0, 16'(win[0]), 16'd3);
        repeat (4) step();
        chk("held_btn_stays_finish", 0, 16'(st[0]), 16'd5);
        btn = 1'b0; step();
        btn = 1'b1; step();
        repeat (15) step();
        chk("held_btn_stays_idle", 0, 16'(st[0]), 16'd0);
        chk("held_btn_stays_idle", 1, 16'(st[1]), 16'd0);

        // Async reset in the middle of a race
        btn = 1'b0; step();
        start_race(1'b1);
        p1x = 10'd0; p1y = 10'd120; p2x = 10'd0; p2y = 10'd120;
        race_tick(3, 3);
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 4; s++) race_tick(s, 3);
        chk("two_laps_before_reset", 0, 16'(l1[0]), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_reset_lap", 0, 16'(l1[0]), 16'd0);
        rst_n = 1'b1;
        cyc = 0;
        repeat (2) step();
        start_race(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
